// File: rtl/spm_ctrl_pkg.sv
// Shared types and width helpers for the multiplier-sharing arbiter.
package spm_ctrl_pkg;

    // Job sequencing states of the arbiter controller.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } spm_state_t;

    // Width of a requester index (ID_W); never narrower than one bit.
    function automatic int id_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    // Width of the watchdog counter (CNT_W), able to hold 0..TIMEOUT.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after last+1.
module rr_arbiter
    import spm_ctrl_pkg::*;
#(
    parameter int R = 4,
    localparam int ID_W = id_width(R)
) (
    input  logic [R-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [R-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] cand;

    // Scan the requests in rotating order and keep the first hit only.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= R; k++) begin
            cand = ID_W'((int'(last) + k) % R);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/spm_arbiter.sv
// Shares one serial-parallel multiplier between R requesters. Jobs are
// granted round-robin, launched with a one-cycle start pulse, bounded by a
// watchdog, and answered on a single response port.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high. The response side holds rsp_* stable while
// rsp_valid is high and rsp_ready is low. Requesters must not make req_valid
// depend on req_ready.
module spm_arbiter
    import spm_ctrl_pkg::*;
#(
    parameter int N       = 32,
    parameter int R       = 4,
    parameter int TIMEOUT = 4 * N + 8,
    localparam int ID_W   = id_width(R),
    localparam int CNT_W  = cnt_width(TIMEOUT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [R-1:0]      req_valid,
    output logic [R-1:0]      req_ready,
    input  logic [R*N-1:0]    req_mp,
    input  logic [R*N-1:0]    req_mc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [2*N-1:0]    rsp_p,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [N-1:0]      spm_mp,
    output logic [N-1:0]      spm_mc,
    output logic              spm_start,
    input  logic [2*N-1:0]    spm_p,
    input  logic              spm_done,
    output spm_state_t        state
);

    logic [ID_W-1:0]  last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [R-1:0]     grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic [N-1:0]     sel_mp;
    logic [N-1:0]     sel_mc;

    rr_arbiter #(.R(R)) u_rr (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Offer the grant only while idle; operands of the winner are muxed out.
    always_comb begin
        req_ready = (state == ST_IDLE) ? grant : '0;
        sel_mp    = req_mp[int'(grant_idx) * N +: N];
        sel_mc    = req_mc[int'(grant_idx) * N +: N];
    end

    // Job sequencer with registered outputs and watchdog counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            last_q      <= ID_W'(R - 1);
            cnt_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_p       <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            spm_mp      <= '0;
            spm_mc      <= '0;
            spm_start   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        spm_mp    <= sel_mp;
                        spm_mc    <= sel_mc;
                        rsp_id    <= grant_idx;
                        last_q    <= grant_idx;
                        spm_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // The start edge also clears any done left from a prior job.
                    spm_start <= 1'b0;
                    cnt_q     <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (spm_done) begin
                        rsp_p       <= spm_p;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Abort: the multiplier keeps running until the next start.
                        rsp_p       <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_arbiter.sv
// Bench for spm_arbiter with a behavioural multiplier stub and a
// transaction-level model of the round-robin job service.
module tb_spm_arbiter;
    import spm_ctrl_pkg::*;

    localparam int N  = 32;
    localparam int R  = 4;
    localparam int TO = 20;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [R-1:0] req_valid, req_ready;
    logic [R*N-1:0] req_mp, req_mc;
    logic rsp_valid, rsp_ready;
    logic [IW-1:0] rsp_id;
    logic [2*N-1:0] rsp_p;
    logic rsp_timeout, busy;
    logic [N-1:0] spm_mp, spm_mc;
    logic spm_start;
    logic [2*N-1:0] spm_p = '0;
    logic spm_done = 1'b0;
    spm_state_t state;

    always #5 clk = ~clk;

    spm_arbiter #(.N(N), .R(R), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mp(req_mp), .req_mc(req_mc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_timeout(rsp_timeout),
        .busy(busy), .spm_mp(spm_mp), .spm_mc(spm_mc),
        .spm_start(spm_start), .spm_p(spm_p), .spm_done(spm_done),
        .state(state)
    );

    // Multiplier stub: done rises mul_lat cycles after the start cycle and
    // is held until the next start; never rises while stuck is set.
    int mul_lat = 4;
    bit stuck = 1'b0;
    int mcnt = 0;
    bit mrun = 1'b0;
    always @(posedge clk) begin
        if (!resetn) begin
            spm_done <= 1'b0; spm_p <= '0; mrun <= 1'b0; mcnt <= 0;
        end else if (spm_start) begin
            spm_done <= 1'b0; mcnt <= mul_lat - 1; mrun <= !stuck;
        end else if (mrun) begin
            if (mcnt <= 1) begin
                spm_done <= 1'b1;
                spm_p <= $signed(spm_mp) * $signed(spm_mc);
                mrun <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    // Model state and scoreboard
    localparam int EW = IW + 2 * N + 1;
    logic [EW-1:0] exp_q[$];
    int due_q[$];
    logic [N-1:0] op_mp[R], op_mc[R];
    logic [R-1:0] pend = '0;
    int last_m = R - 1;
    bit m_busy = 1'b0;
    int acc_cyc = -100;
    int cyc = 0;
    bit seen = 1'b0;
    int rr_mode = 0;
    int force_lat = 0;
    int total = 0, bad = 0;
    int order_q[$];
    logic [2*N-1:0] last_p = '0;
    logic [IW-1:0] last_id = '0;
    logic last_to = 1'b0;
    logic [N-1:0] acc_mp = '0, acc_mc = '0;
    int acc_w = -1;
    bit do_pop = 1'b0;
    int acc_lat = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int winner();
        for (int k = 1; k <= R; k++) begin
            if (pend[(last_m + k) % R]) return (last_m + k) % R;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int mp, input int mc);
        op_mp[i] = mp;
        op_mc[i] = mc;
        req_mp[i*N +: N] = mp;
        req_mc[i*N +: N] = mc;
        pend[i] = 1'b1;
        req_valid = pend;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spm_mp", spm_mp, 0);
        chk("rst_spm_mc", spm_mc, 0);
        chk("rst_spm_start", spm_start, 0);
        chk("rst_state", state, ST_IDLE);
    endtask

    // One-edge reset; the model forgets any job in flight.
    task automatic do_reset();
        resetn = 1'b0;
        pend = '0;
        req_valid = '0;
        @(posedge clk); #1; cyc++;
        resetn = 1'b1;
        exp_q.delete(); due_q.delete();
        seen = 1'b0; m_busy = 1'b0; last_m = R - 1; acc_cyc = -100;
        #1;
        check_reset_outputs();
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_cycle();
        int w;
        logic [R-1:0] er;
        int a, b;
        longint pr;
        acc_w = -1;
        do_pop = 1'b0;
        chk("busy", busy, m_busy);
        chk("spm_start", spm_start, (cyc == acc_cyc + 1));
        if (m_busy) begin
            chk("spm_mp", spm_mp, acc_mp);
            chk("spm_mc", spm_mc, acc_mc);
        end
        w = m_busy ? -1 : winner();
        er = (w >= 0) ? R'(1 << w) : '0;
        chk("req_ready", req_ready, er);
        if (exp_q.size() == 0) begin
            chk("rsp_spurious", rsp_valid, 0);
        end else begin
            chk("rsp_valid", rsp_valid, (seen || cyc >= due_q[0]));
            if (rsp_valid) begin
                seen = 1'b1;
                chk("rsp_id", rsp_id, exp_q[0][EW-1 -: IW]);
                chk("rsp_p", rsp_p, exp_q[0][2*N:1]);
                chk("rsp_timeout", rsp_timeout, exp_q[0][0]);
                if (rsp_ready) begin
                    do_pop = 1'b1;
                    last_p = rsp_p; last_id = rsp_id; last_to = rsp_timeout;
                end
            end
        end
        if (w >= 0) begin
            acc_w = w;
            acc_lat = (force_lat > 0) ? force_lat : $urandom_range(2, 20);
            mul_lat = acc_lat;
            a = op_mp[w];
            b = op_mc[w];
            pr = longint'(a) * longint'(b);
            acc_mp = op_mp[w];
            acc_mc = op_mc[w];
            if (stuck) exp_q.push_back({IW'(w), 64'd0, 1'b1});
            else exp_q.push_back({IW'(w), 64'(pr), 1'b0});
            due_q.push_back(cyc + 2 + (stuck ? TO : acc_lat));
        end
    endtask

    task automatic tick();
        #1;
        check_cycle();
        @(posedge clk); #1; cyc++;
        if (do_pop) begin
            order_q.push_back(int'(last_id));
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            seen = 1'b0;
            m_busy = 1'b0;
        end
        if (acc_w >= 0) begin
            pend[acc_w] = 1'b0;
            last_m = acc_w;
            m_busy = 1'b1;
            acc_cyc = cyc - 1;
        end
        req_valid = pend;
        case (rr_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((pend != 0 || m_busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $error("FAIL run_idle: budget %0d cycles expired, jobs left %0d", budget, exp_q.size());
        end
    endtask

    initial begin
        req_valid = '0; req_mp = '0; req_mc = '0; rsp_ready = 1'b1;
        for (int i = 0; i < R; i++) begin op_mp[i] = '0; op_mc[i] = '0; end
        @(posedge clk);
        do_reset();

        // Single job from requester 0
        set_req(0, 3, 5);
        run_idle(200);
        chk("t1_p", last_p, 64'd15);
        chk("t1_id", last_id, 0);
        chk("t1_to", last_to, 0);

        // Signed job from requester 2
        set_req(2, -7, 6);
        run_idle(200);
        chk("t2_p", last_p, 64'hFFFF_FFFF_FFFF_FFD6);
        chk("t2_id", last_id, 2);

        // All four from reset, then 1 and 3 with last = 3
        do_reset();
        order_q.delete();
        for (int i = 0; i < R; i++) set_req(i, int'($urandom), int'($urandom));
        run_idle(400);
        chk("t3_cnt", order_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_order", order_q[i], i);
        order_q.delete();
        set_req(3, int'($urandom), int'($urandom));
        set_req(1, int'($urandom), int'($urandom));
        run_idle(200);
        chk("t3b_cnt", order_q.size(), 2);
        chk("t3b_first", order_q[0], 1);
        chk("t3b_second", order_q[1], 3);

        // Backpressure: hold the response for 10 cycles with another request waiting
        order_q.delete();
        rr_mode = 2; rsp_ready = 1'b0;
        set_req(0, int'($urandom), int'($urandom));
        set_req(1, int'($urandom), int'($urandom));
        begin
            int n = 0;
            while (!seen && n < 100) begin tick(); n++; end
            if (!seen) begin
                total++; bad++;
                $error("FAIL bp_wait: no response within 100 cycles");
            end
        end
        repeat (10) tick();
        rr_mode = 0; rsp_ready = 1'b1;
        run_idle(200);
        chk("t4_cnt", order_q.size(), 2);
        chk("t4_first", order_q[0], 0);
        chk("t4_second", order_q[1], 1);

        // Latency boundaries: done on the last WAIT cycle, and the fastest job
        force_lat = 20;
        set_req(2, -1, -1);
        run_idle(200);
        chk("t5_late_to", last_to, 0);
        chk("t5_late_p", last_p, 64'd1);
        force_lat = 2;
        set_req(3, 32'h8000_0000, 32'h8000_0000);
        run_idle(200);
        chk("t5_fast_p", last_p, 64'h4000_0000_0000_0000);
        force_lat = 0;

        // Random traffic with random response backpressure
        rr_mode = 1;
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < R; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom), int'($urandom));
            repeat ($urandom_range(0, 30)) tick();
        end
        run_idle(3000);
        rr_mode = 0; rsp_ready = 1'b1;

        // Watchdog
        stuck = 1'b1;
        set_req(3, 9, 9);
        run_idle(200);
        chk("t7_to", last_to, 1);
        chk("t7_p", last_p, 0);
        chk("t7_id", last_id, 3);
        stuck = 1'b0;

        // Reset in the middle of WAIT, then a fresh job
        force_lat = 20;
        set_req(1, 11, 13);
        begin
            int n = 0;
            while (!(m_busy && cyc == acc_cyc + 5) && n < 100) begin tick(); n++; end
            chk("t8_in_wait", state, ST_WAIT);
        end
        do_reset();
        force_lat = 0;
        repeat (25) tick();
        set_req(0, -100, 77);
        run_idle(200);
        chk("t8_id", last_id, 0);
        chk("t8_p", last_p, 64'hFFFF_FFFF_FFFF_E1EC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_arbiter.md
# spm_arbiter

Shares one `SerialParallelMultiplier` instance between R requesters. Each requester sends an operand pair over a valid/ready request port. The block grants requesters round-robin, drives the multiplier's operand and `start` pins for each job, and waits for `done`. It then returns the 2N-bit signed product, tagged with the requester id, on a single valid/ready response port. A watchdog bounds each job. The block sits between the bus-facing request logic and the multiplier datapath.

## Interface
- `N`, 32: operand width; the multiplier instance uses the same N.
- `R`, 4: number of requesters, R ≥ 2.
- `TIMEOUT`, 4*N+8: WAIT-state cycle limit before a job is aborted.
- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset; also wired to the multiplier's `resetn`.
- `req_valid`  in  R  per-requester request valid.
- `req_ready`  out  R  per-requester accept; at most one bit set.
- `req_mp`  in  R*N  multiplier operands, requester i at bits [i*N +: N].
- `req_mc`  in  R*N  multiplicand operands, same packing.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  $clog2(R)  index of the requester being answered.
- `rsp_p`  out  2N  signed product.
- `rsp_timeout`  out  1  job aborted by the watchdog; `rsp_p` = 0.
- `busy`  out  1  high in any state other than IDLE.
- `spm_mp`, `spm_mc`  out  N  operands to the multiplier.
- `spm_start`  out  1  multiplier start.
- `spm_p`  in  2N  multiplier product.
- `spm_done`  in  1  multiplier done.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE
  - The arbiter picks the first valid requester starting at `last+1` (mod R).
  - `req_ready[g]` = 1 for that winner only. This is combinational from `req_valid` and registered state.
  - Requesters must not make `req_valid` depend on `req_ready`.
  - On handshake:
    - latch `req_mp[g]` and `req_mc[g]` into `spm_mp`/`spm_mc`;
    - latch `g` into `rsp_id` and update `last`;
    - go to LAUNCH.
- LAUNCH: `spm_start` = 1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT
  - `spm_start` = 0; the counter increments each cycle.
  - On `spm_done` = 1: capture `spm_p` into `rsp_p`, set `rsp_timeout` = 0, go to RESP.
  - Else, when the counter reaches TIMEOUT-1: set `rsp_p` = 0 and `rsp_timeout` = 1, go to RESP.
- RESP: `rsp_valid` = 1; `rsp_*` are held stable until `rsp_ready` = 1, then go to IDLE.
- `spm_mp`/`spm_mc` stay constant from LAUNCH through RESP, because the multiplier samples MP every cycle of a job.
- Product semantics are signed×signed, two's complement, 2N bits. No truncation or saturation.
- Reset values (`resetn` = 0 at a rising edge):
  - state = IDLE, `last` = R-1 (requester 0 has first priority);
  - all outputs 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_p`, `rsp_timeout`, `busy`, `spm_mp`, `spm_mc`, `spm_start`.

## Timing
- Accept edge T → `spm_start` high in cycle T+1 → WAIT from T+2.
- `rsp_valid` rises one cycle after the first cycle in which `spm_done` is seen high in WAIT.
- No request is accepted while `busy`; one job in flight.
- Maximum throughput: one job per (3 + multiplier latency) cycles with `rsp_ready` tied high.
- `spm_done` is sampled only in WAIT. A stale `done` held from the previous job is already cleared by the start edge in LAUNCH.
- Timeout leaves the multiplier running. The next LAUNCH restarts it, because a start edge overrides any in-progress job.
- Simultaneous requests are resolved by round-robin only; the grant is not sticky across jobs.
- Reset mid-operation (any state) aborts the job. No response is issued and the pending operands are discarded.

## Structure
- Package `spm_ctrl_pkg`:
  - state enum (IDLE/LAUNCH/WAIT/RESP);
  - `ID_W` = $clog2(R) and `CNT_W` = $clog2(TIMEOUT+1) width helpers.
- Sub-module `rr_arbiter` (R-bit request, `last` pointer in, one-hot grant plus encoded index out). Purely combinational; `last` is owned by `spm_arbiter`.
- The multiplier is instantiated outside this block; it is connected in the bench and top level.

## Test plan
- Single job, req 0: mp = 3, mc = 5 → exactly one `spm_start` pulse; `rsp_valid` with `rsp_id` = 0, `rsp_p` = 15, `rsp_timeout` = 0.
- Signed job, req 2: mp = -7, mc = 6 → `rsp_p` = 0xFFFF_FFFF_FFFF_FFD6, `rsp_id` = 2.
- All four `req_valid` high from reset, distinct operands → responses in id order 0, 1, 2, 3. Then reqs 1 and 3 (`last` = 3) → order 1, 3.
- Backpressure: `rsp_ready` = 0 for 10 cycles during RESP → `rsp_*` stable, `req_ready` = 0 throughout, next grant only after the handshake.
- Watchdog: stub multiplier with `spm_done` tied 0, TIMEOUT = 20 → `rsp_valid` with `rsp_timeout` = 1 and `rsp_p` = 0, 20 cycles after entering WAIT.
- `resetn` low for one edge mid-WAIT → next cycle in IDLE with all outputs 0, no response for the aborted job. A fresh request from req 0 then completes correctly.
